// File: rtl/flog_post_pkg.sv
// Shared constants and types for the bfloat16 log post-processing stage.
package flog_post_pkg;

    localparam int OUT_WIDTH_PHILO = 16;
    localparam int BF16_EXP_W      = 8;
    localparam int BF16_BIAS       = 127;

    // ln(2) in Q0.16
    localparam logic [15:0] LN2_Q16 = 16'hB172;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } ss_post_t;

endpackage

// File: rtl/flog_post_if.sv
// Handshake and data bundle between the log2(mantissa) stage and flog_post.
interface flog_post_if
    import flog_post_pkg::*;
#(
    parameter int FRAC_W = OUT_WIDTH_PHILO,
    parameter int EXP_W  = BF16_EXP_W
) ();

    logic              valid_i;
    logic              ready_o;
    logic [EXP_W-1:0]  exp_i;
    logic [FRAC_W-1:0] frac_i;
    logic              special_i;
    logic [15:0]       special_val_i;
    logic              valid_o;
    logic [15:0]       result_o;

    // Upstream side: presents operands, observes result
    modport master (
        output valid_i, exp_i, frac_i, special_i, special_val_i,
        input  ready_o, valid_o, result_o
    );

    // flog_post side
    modport slave (
        input  valid_i, exp_i, frac_i, special_i, special_val_i,
        output ready_o, valid_o, result_o
    );

endinterface

// File: rtl/flog_post.sv
// Final bfloat16 ln(x) stage: combines exponent and log2 fraction into
// fixed-point log2(x), scales by ln2, normalises by iterative left shift
// and packs a truncated bfloat16 result. Special cases bypass the datapath.
module flog_post
    import flog_post_pkg::*;
#(
    parameter int FRAC_W = OUT_WIDTH_PHILO,
    parameter int EXP_W  = BF16_EXP_W,
    parameter int LN2_W  = 16
) (
    input  logic        clk,
    input  logic        rst,
    flog_post_if.slave  bus
);

    localparam int MAG_W = EXP_W + FRAC_W;
    localparam int PW    = MAG_W + LN2_W;
    localparam int SH_W  = $clog2(PW) + 1;

    // Exponent of a product whose MSB already sits at PW-1
    localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(BF16_BIAS + EXP_W - 1);

    ss_post_t          state_q, state_d;
    logic              sign_q, sign_d;
    logic [MAG_W-1:0]  mag_q, mag_d;
    logic              special_q, special_d;
    logic [15:0]       sval_q, sval_d;
    logic [PW-1:0]     p_q, p_d;
    logic [SH_W-1:0]   sh_q, sh_d;
    logic [15:0]       result_q, result_d;

    logic signed [EXP_W:0]   e_unb;
    logic [EXP_W+FRAC_W:0]   l_raw;

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sign_q    <= 1'b0;
            mag_q     <= '0;
            special_q <= 1'b0;
            sval_q    <= '0;
            p_q       <= '0;
            sh_q      <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            mag_q     <= mag_d;
            special_q <= special_d;
            sval_q    <= sval_d;
            p_q       <= p_d;
            sh_q      <= sh_d;
            result_q  <= result_d;
        end
    end

    // Next-state, datapath updates and handshake outputs
    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        mag_d     = mag_q;
        special_d = special_q;
        sval_d    = sval_q;
        p_d       = p_q;
        sh_d      = sh_q;
        result_d  = result_q;

        // Signed fixed-point log2(x); magnitude fits MAG_W since |exp-127| <= 127
        e_unb = $signed({1'b0, bus.exp_i}) - $signed((EXP_W + 1)'(BF16_BIAS));
        l_raw = {e_unb, bus.frac_i};

        bus.ready_o  = (state_q == IDLE);
        bus.valid_o  = (state_q == DONE);
        bus.result_o = result_q;

        case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    sign_d    = l_raw[EXP_W+FRAC_W];
                    mag_d     = l_raw[EXP_W+FRAC_W] ? (~l_raw[MAG_W-1:0] + 1'b1)
                                                    : l_raw[MAG_W-1:0];
                    special_d = bus.special_i;
                    sval_d    = bus.special_val_i;
                    state_d   = MULT;
                end
            end
            MULT: begin
                p_d  = {{LN2_W{1'b0}}, mag_q} * {{MAG_W{1'b0}}, LN2_Q16};
                sh_d = '0;
                if (special_q) begin
                    result_d = sval_q;
                    state_d  = DONE;
                end else if (mag_q == '0) begin
                    result_d = 16'h0000;
                    state_d  = DONE;
                end else begin
                    state_d  = NORM;
                end
            end
            NORM: begin
                if (!p_q[PW-1]) begin
                    p_d  = p_q << 1;
                    sh_d = sh_q + 1'b1;
                end else begin
                    result_d = {sign_q, EXP_TOP - EXP_W'(sh_q), p_q[PW-2 -: 7]};
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
